// File: rtl/rv_pkg.sv
// Shared RV32I encodings, step indices and decode helpers for the rv_core slice.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package rv_pkg;

  typedef logic [6:0] step_t;

  // Major opcodes
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // ALU funct3
  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  // Load/store funct3 (size in bits [1:0], unsigned flag in bit 2)
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // One-hot step bit positions
  localparam int S_FETCH = 0;
  localparam int S_CAPT  = 1;
  localparam int S_DEC   = 2;
  localparam int S_EXEC  = 3;
  localparam int S_MREQ  = 4;
  localparam int S_MDATA = 5;
  localparam int S_WB    = 6;

  localparam step_t STEP_FIRST = 7'b0000001;
  localparam step_t STEP_HALT  = 7'b0000000;

  // Immediate for the instruction's encoding format
  function automatic logic [31:0] imm_of(input logic [31:0] insn);
    logic [31:0] imm;
    case (insn[6:0])
      OP_LUI, OP_AUIPC: imm = {insn[31:12], 12'b0};
      OP_JAL:           imm = {{12{insn[31]}}, insn[19:12], insn[20], insn[30:21], 1'b0};
      OP_BRANCH:        imm = {{20{insn[31]}}, insn[7], insn[30:25], insn[11:8], 1'b0};
      OP_STORE:         imm = {{21{insn[31]}}, insn[30:25], insn[11:7]};
      default:          imm = {{21{insn[31]}}, insn[30:20]};
    endcase
    return imm;
  endfunction

  // SYSTEM (ECALL/EBREAK/CSR) is deliberately reported as not legal so it traps
  function automatic logic insn_legal(input logic [31:0] insn);
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ok;
    f3 = insn[14:12];
    f7 = insn[31:25];
    case (insn[6:0])
      OP_LUI, OP_AUIPC, OP_JAL, OP_FENCE: ok = 1'b1;
      OP_JALR:   ok = (f3 == 3'd0);
      OP_BRANCH: ok = (f3 != 3'd2) && (f3 != 3'd3);
      OP_LOAD:   ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
      OP_STORE:  ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      OP_IMM: begin
        if (f3 == F3_SLL)     ok = (f7 == 7'h00);
        else if (f3 == F3_SR) ok = (f7 == 7'h00) || (f7 == 7'h20);
        else                  ok = 1'b1;
      end
      OP_OP:     ok = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == F3_ADD) || (f3 == F3_SR)));
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rv_core_if.sv
// Unified memory bus between the core sequencer and its word memory.
// Latency: read data valid one cycle after raddr; writes land on the clock edge.
// Backpressure: none, the memory always accepts.
interface rv_core_if;
  logic [31:0] raddr;
  logic [31:0] rdata;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        we;

  modport master (output raddr, waddr, wdata, wstrb, we, input rdata);
  modport slave  (input raddr, waddr, wdata, wstrb, we, output rdata);
endinterface

// File: rtl/rv_mem.sv
// Unified instruction/data word memory with byte-lane write enables.
// Latency: registered read, one cycle; write on the same edge as we.
// Backpressure: none.
module rv_mem #(
  parameter int MEM_WORDS = 4096
) (
  input  logic        clk,
  input  logic [31:0] raddr,
  output logic [31:0] rdata,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        we
);
  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0] mem [0:MEM_WORDS-1];

  // Byte addresses wrap: only the word-index bits select a location
  logic unused_addr_bits;
  assign unused_addr_bits = ^{raddr[31:AW+2], raddr[1:0], waddr[31:AW+2], waddr[1:0]};

  // Registered read plus per-lane write
  always_ff @(posedge clk) begin
    rdata <= mem[raddr[AW+1:2]];
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[waddr[AW+1:2]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end
endmodule

// File: rtl/rv_core.sv
// Multi-cycle RV32I core: one-hot 7-step sequencer, inline decode/ALU/regfile, unified memory.
// Latency: 7 cycles per instruction; trap raised at the offending instruction's writeback step.
// Backpressure: none; memory is fixed-latency and the core halts (step=0) once trapped.
module rv_core import rv_pkg::*; #(
  parameter int          MEM_WORDS = 4096,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic clk,
  input  logic resetn,
  output logic trap
);
  step_t       step, step_nxt;
  logic [31:0] pc, i_data;
  logic [6:0]  opcode;
  logic [2:0]  alu_func;
  logic        alu_alt;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] alu_left, alu_imm, rs2_val;
  logic        bad_insn;
  logic [31:0] alu_out, pc_next;
  logic        pend;
  logic [31:0] d_addr, d_data, ld_word;
  logic [31:0] regs [0:31];

  logic [31:0] op_b, alu_res, ld_sh, ld_ext, wb_val;
  logic        br_take, mis_mem, mis_pc, trap_cond, writes_rd, is_mem;
  logic [3:0]  strb;

  rv_core_if bus ();

  rv_mem #(.MEM_WORDS(MEM_WORDS)) r (
    .clk   (clk),
    .raddr (bus.raddr),
    .rdata (bus.rdata),
    .waddr (bus.waddr),
    .wdata (bus.wdata),
    .wstrb (bus.wstrb),
    .we    (bus.we)
  );

  // Register indices are kept for debug visibility; operands are read at decode
  logic unused_dbg;
  assign unused_dbg = ^{rs1, rs2, pend};

  // Step register: one-hot sequencer, cleared to the halt code on trap
  always_ff @(posedge clk) begin
    if (resetn) step <= STEP_FIRST;
    else        step <= step_nxt;
  end

  // Next step: rotate, wrap after writeback unless trapping; halt code stays put
  always_comb begin
    step_nxt = {step[5:0], 1'b0};
    if (step[S_WB] && !trap_cond) step_nxt = STEP_FIRST;
  end

  // Memory port drive: fetch address except during the data request step
  always_comb begin
    bus.raddr = step[S_MREQ] ? d_addr : pc;
    bus.waddr = d_addr;
    bus.wdata = d_data;
    bus.wstrb = strb;
    bus.we    = step[S_MREQ] && (opcode == OP_STORE) && !mis_mem && !bad_insn && !resetn;
  end

  // ALU and branch compare on decoded operands
  always_comb begin
    op_b = (opcode == OP_OP) ? rs2_val : alu_imm;
    case (alu_func)
      F3_ADD:  alu_res = (opcode == OP_OP && alu_alt) ? alu_left - op_b : alu_left + op_b;
      F3_SLL:  alu_res = alu_left << op_b[4:0];
      F3_SLT:  alu_res = {31'b0, $signed(alu_left) < $signed(op_b)};
      F3_SLTU: alu_res = {31'b0, alu_left < op_b};
      F3_XOR:  alu_res = alu_left ^ op_b;
      F3_SR:   alu_res = alu_alt ? 32'($signed(alu_left) >>> op_b[4:0]) : alu_left >> op_b[4:0];
      F3_OR:   alu_res = alu_left | op_b;
      default: alu_res = alu_left & op_b;
    endcase
    case (alu_func)
      F3_BEQ:  br_take = (alu_left == rs2_val);
      F3_BNE:  br_take = (alu_left != rs2_val);
      F3_BLT:  br_take = ($signed(alu_left) < $signed(rs2_val));
      F3_BGE:  br_take = ($signed(alu_left) >= $signed(rs2_val));
      F3_BLTU: br_take = (alu_left < rs2_val);
      F3_BGEU: br_take = (alu_left >= rs2_val);
      default: br_take = 1'b0;
    endcase
  end

  // Alignment, byte lanes, load extension and trap decision
  always_comb begin
    is_mem  = (opcode == OP_LOAD) || (opcode == OP_STORE);
    mis_mem = is_mem && (((alu_func[1:0] == 2'b01) && d_addr[0]) ||
                         ((alu_func[1:0] == 2'b10) && (d_addr[1:0] != 2'b00)));
    // pc is always word aligned, so only taken targets can set bit 1
    mis_pc  = pc_next[1];
    trap_cond = bad_insn || mis_mem || mis_pc;
    case (alu_func[1:0])
      2'b00:   strb = 4'b0001 << d_addr[1:0];
      2'b01:   strb = d_addr[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
    ld_sh = ld_word >> {d_addr[1:0], 3'b000};
    case (alu_func)
      F3_B:    ld_ext = {{24{ld_sh[7]}}, ld_sh[7:0]};
      F3_H:    ld_ext = {{16{ld_sh[15]}}, ld_sh[15:0]};
      F3_BU:   ld_ext = {24'b0, ld_sh[7:0]};
      F3_HU:   ld_ext = {16'b0, ld_sh[15:0]};
      default: ld_ext = ld_sh;
    endcase
    wb_val    = (opcode == OP_LOAD) ? ld_ext : alu_out;
    writes_rd = (opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL) ||
                (opcode == OP_JALR) || (opcode == OP_LOAD) || (opcode == OP_IMM) || (opcode == OP_OP);
  end

  // Per-step datapath latches: capture, decode, execute, load data
  always_ff @(posedge clk) begin
    if (step[S_CAPT]) i_data <= bus.rdata;
    if (step[S_DEC]) begin
      opcode   <= i_data[6:0];
      alu_func <= i_data[14:12];
      alu_alt  <= i_data[30];
      rs1      <= i_data[19:15];
      rs2      <= i_data[24:20];
      rd       <= i_data[11:7];
      alu_imm  <= imm_of(i_data);
      alu_left <= regs[i_data[19:15]];
      rs2_val  <= regs[i_data[24:20]];
      bad_insn <= !insn_legal(i_data);
    end
    if (step[S_EXEC]) begin
      d_addr <= alu_left + alu_imm;
      case (alu_func[1:0])
        2'b00:   d_data <= {4{rs2_val[7:0]}};
        2'b01:   d_data <= {2{rs2_val[15:0]}};
        default: d_data <= rs2_val;
      endcase
      case (opcode)
        OP_LUI:          alu_out <= alu_imm;
        OP_AUIPC:        alu_out <= pc + alu_imm;
        OP_JAL, OP_JALR: alu_out <= pc + 32'd4;
        default:         alu_out <= alu_res;
      endcase
      case (opcode)
        OP_JAL:    pc_next <= pc + alu_imm;
        OP_JALR:   pc_next <= (alu_left + alu_imm) & ~32'd1;
        OP_BRANCH: pc_next <= br_take ? pc + alu_imm : pc + 32'd4;
        default:   pc_next <= pc + 32'd4;
      endcase
    end
    if (step[S_MDATA]) ld_word <= bus.rdata;
  end

  // Architectural state: pc, register file, pend and sticky trap
  always_ff @(posedge clk) begin
    if (resetn) begin
      pc   <= RESET_PC;
      trap <= 1'b0;
      pend <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      if (step[S_EXEC])  pend <= is_mem;
      if (step[S_MDATA]) pend <= 1'b0;
      if (step[S_WB]) begin
        if (trap_cond) begin
          trap <= 1'b1;
        end else begin
          pc <= pc_next;
          if (writes_rd && (rd != 5'd0)) regs[rd] <= wb_val;
        end
      end
    end
  end
endmodule

// File: tb/tb_rv_core.sv
// Directed test of rv_core: reset, ALU, loads/stores, control flow and traps.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_rv_core;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic trap;
  int   n_checks = 0;
  int   n_errors = 0;

  rv_core #(.MEM_WORDS(4096), .RESET_PC(32'h0)) dut (
    .clk    (clk),
    .resetn (resetn),
    .trap   (trap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    resetn = 1'b1;
    tick(1);
    resetn = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) dut.r.mem[i] = 32'h0;
  endtask

  initial begin
    // ---------------- Program 1: ALU, memory, x0, illegal opcode
    clear_mem();
    dut.r.mem[0]  = 32'h00500513; // addi x10,x0,5
    dut.r.mem[1]  = 32'hFFD00593; // addi x11,x0,-3
    dut.r.mem[2]  = 32'h00459613; // slli x12,x11,4
    dut.r.mem[3]  = 32'h40265693; // srai x13,x12,2
    dut.r.mem[4]  = 32'h00B03733; // sltu x14,x0,x11
    dut.r.mem[5]  = 32'h40B507B3; // sub  x15,x10,x11
    dut.r.mem[6]  = 32'h10B02023; // sw   x11,0x100(x0)
    dut.r.mem[7]  = 32'h10000803; // lb   x16,0x100(x0)
    dut.r.mem[8]  = 32'h10205883; // lhu  x17,0x102(x0)
    dut.r.mem[9]  = 32'h00700013; // addi x0,x0,7
    dut.r.mem[10] = 32'h0000007F; // illegal
    do_reset();
    check("rst_step", 32'(dut.step), 32'h01);
    check("rst_pc", dut.pc, 32'h0);
    check("rst_trap", 32'(trap), 32'h0);
    check("rst_pend", 32'(dut.pend), 32'h0);
    tick(6);
    check("wb_step", 32'(dut.step), 32'h40);
    check("pre_wb_x10", dut.regs[10], 32'h0);
    tick(1);
    check("x10", dut.regs[10], 32'h5);
    check("pc_1", dut.pc, 32'h4);
    check("step_wrap", 32'(dut.step), 32'h01);
    tick(7);
    check("x11", dut.regs[11], 32'hFFFFFFFD);
    check("pc_2", dut.pc, 32'h8);
    tick(7 * 5);
    check("x12", dut.regs[12], 32'hFFFFFFD0);
    check("x13", dut.regs[13], 32'hFFFFFFF4);
    check("x14", dut.regs[14], 32'h1);
    check("x15", dut.regs[15], 32'h8);
    check("mem64", dut.r.mem[64], 32'hFFFFFFFD);
    tick(4);
    check("pend_ld", 32'(dut.pend), 32'h1);
    tick(3);
    check("x16", dut.regs[16], 32'hFFFFFFFD);
    tick(7);
    check("x17", dut.regs[17], 32'h0000FFFF);
    tick(7);
    check("x0", dut.regs[0], 32'h0);
    check("pc_x0", dut.pc, 32'h28);
    tick(6);
    check("ill_pre_trap", 32'(trap), 32'h0);
    tick(1);
    check("ill_trap", 32'(trap), 32'h1);
    check("ill_pc", dut.pc, 32'h28);
    check("ill_step", 32'(dut.step), 32'h0);
    tick(10);
    check("ill_hold_step", 32'(dut.step), 32'h0);
    check("ill_hold_pc", dut.pc, 32'h28);
    check("ill_hold_trap", 32'(trap), 32'h1);

    // ---------------- Program 2: control flow and misaligned load
    dut.r.mem[0] = 32'h00000463; // beq  x0,x0,+8
    dut.r.mem[1] = 32'h0000007F; // skipped; traps if executed
    dut.r.mem[2] = 32'h00C000EF; // jal  x1,+12
    dut.r.mem[3] = 32'h00001463; // bne  x0,x0,+8 (not taken)
    dut.r.mem[4] = 32'h10102283; // lw   x5,0x101(x0) misaligned
    dut.r.mem[5] = 32'h00008067; // jalr x0,0(x1)
    do_reset();
    check("rst2_x10", dut.regs[10], 32'h0);
    check("rst2_trap", 32'(trap), 32'h0);
    check("rst2_pc", dut.pc, 32'h0);
    tick(7);
    check("beq_pc", dut.pc, 32'h8);
    tick(7);
    check("jal_x1", dut.regs[1], 32'hC);
    check("jal_pc", dut.pc, 32'h14);
    tick(7);
    check("jalr_pc", dut.pc, 32'hC);
    tick(7);
    check("bne_pc", dut.pc, 32'h10);
    check("bne_trap", 32'(trap), 32'h0);
    tick(7);
    check("lw_mis_trap", 32'(trap), 32'h1);
    check("lw_mis_pc", dut.pc, 32'h10);
    check("lw_mis_x5", dut.regs[5], 32'h0);

    // ---------------- Program 3: ecall and recovery by reset
    dut.r.mem[0] = 32'h00100193; // addi x3,x0,1
    dut.r.mem[1] = 32'h00000073; // ecall
    do_reset();
    tick(13);
    check("ecall_pre_trap", 32'(trap), 32'h0);
    tick(1);
    check("ecall_trap", 32'(trap), 32'h1);
    check("ecall_x3", dut.regs[3], 32'h1);
    check("ecall_pc", dut.pc, 32'h4);
    tick(3);
    check("ecall_step", 32'(dut.step), 32'h0);
    do_reset();
    check("rst3_trap", 32'(trap), 32'h0);
    check("rst3_pc", dut.pc, 32'h0);
    check("rst3_step", 32'(dut.step), 32'h01);
    check("rst3_x3", dut.regs[3], 32'h0);
    check("rst3_mem", dut.r.mem[0], 32'h00100193);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/rv_core.md
Name: rv_core

Overview:
- Multi-cycle RV32I integer core with its own unified instruction/data memory and a 32x32 register file; the top-level CPU block of the system.
- Executes every instruction through a fixed 7-step one-hot sequencer.
- Raises `trap` and halts on ECALL, EBREAK or any illegal or misaligned event.
- Memory is preloaded by the environment with word-wide hex data through hierarchical path `r.mem`. Reset does not clear it.

Parameters:
- MEM_WORDS, 4096, depth of the unified 32-bit memory, word-addressed by addr[log2(MEM_WORDS)+1:2].
- RESET_PC, 32'h0, fetch address after reset.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  synchronous reset, active-high despite the name. A one-cycle high pulse fully resets the core.
- trap  output  1  high once the core has halted. Sticky until reset.

Behaviour:
- Internal names are visible for hierarchical debug and must exist exactly:
  - step[6:0], pc, i_data, opcode[6:0], alu_func[2:0] (funct3), alu_alt (instr[30]), alu_left (operand A), alu_imm (decoded immediate).
  - pend (load/store in flight), d_addr, d_data (load/store address and write data), rs1, rs2, rd (register indices).
  - regs[0:31], memory instance `r` holding array mem[0:MEM_WORDS-1].
- Reset (resetn=1 at posedge):
  - pc=RESET_PC, step=7'b0000001, trap=0, pend=0, regs[1..31]=0.
  - Memory contents are untouched.
  - Reset mid-instruction aborts it with no register or memory write.
- regs[0] reads 0 always; writes to x0 are discarded.
- Step sequence, one step per cycle, every instruction visits all seven, so CPI=7:
  - step[0] fetch: present pc to memory read port.
  - step[1] capture: latch the instruction word into i_data.
  - step[2] decode: latch opcode, alu_func, alu_alt, rs1, rs2, rd, alu_imm; read alu_left=regs[rs1] and the rs2 value.
  - step[3] execute: compute the ALU result, branch decision and d_addr=rs1+imm; set pend for LOAD/STORE.
  - step[4] memory request: LOAD issues the read; STORE writes d_data with byte enables. Others idle.
  - step[5] memory data: LOAD captures the read word; clear pend.
  - step[6] writeback: write rd, update pc, return to step[0].
- Instruction set:
  - Full RV32I: LUI, AUIPC, JAL, JALR, all six branches, LB/LH/LW/LBU/LHU, SB/SH/SW.
  - OP-IMM and OP: ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND. Shifts use the low 5 bits of the shift amount.
  - FENCE executes as a NOP.
- Width and data rules:
  - All arithmetic is 32-bit wrap-around.
  - Loads sign- or zero-extend per funct3.
  - Stores replicate data into the addressed byte lanes.
  - JAL and JALR write pc+4 to rd; JALR clears target bit 0.
  - Untaken branches and all other instructions set pc=pc+4.
- Memory:
  - Synchronous read with one-cycle latency; write on the clock edge.
  - Addresses wrap modulo MEM_WORDS*4.
- Trap conditions, evaluated at step[6]:
  - ECALL, EBREAK, or an unknown opcode or funct.
  - Halfword access with addr[0]=1, or word access with addr[1:0]!=0.
  - Jump or taken-branch target with bit 1 set.
- On trap:
  - No rd write and no memory write for the offending instruction; pc holds.
  - trap=1, step freezes at 7'b0000000 until reset.

Decomposition:
- Package rv_pkg:
  - Opcode constants: OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_OP, OP_FENCE, OP_SYSTEM.
  - funct3 constants for ALU, branch and load/store.
  - Step-index constants.
- One sub-module, rv_mem, instantiated as `r`: parameter MEM_WORDS; ports clk, raddr, rdata (registered), waddr, wdata, wstrb[3:0], we; array `mem`.
- Decode, ALU and register file stay inline.

Test Plan:
- Reset and fetch:
  - Stimulus: mem[0]=addi x10,x0,5 (32'h00500513); pulse resetn one cycle.
  - Response: step=0000001 the cycle after reset; at the first step[6], regs[10]=5 and pc 0->4.
  - Response: 7 cycles per instruction (second retire exactly 7 cycles later).
- ALU:
  - Stimulus: addi x11,x0,-3; slli x12,x11,4; srai x13,x12,2; sltu x14,x0,x11; sub x15,x10,x11.
  - Response: x11=FFFFFFFD, x12=FFFFFFD0, x13=FFFFFFF4, x14=1, x15=8 (x10=5).
- Memory:
  - Stimulus: sw x11,0x100(x0); lb x16,0x100(x0); lhu x17,0x102(x0).
  - Response: mem[64]=FFFFFFFD, x16=FFFFFFFD, x17=0000FFFF.
  - Stimulus: lw from 0x101.
  - Response: trap=1, pc holds.
- Control flow:
  - Stimulus: beq x0,x0,+8.
  - Response: pc 0->8.
  - Stimulus: jal x1,+12 at pc=8.
  - Response: x1=0xC, pc=0x14.
  - Stimulus: jalr x0,0(x1).
  - Response: pc=0xC.
  - Stimulus: bne x0,x0,+8.
  - Response: pc+4.
- Trap:
  - Stimulus: addi x3,x0,1; ecall.
  - Response: trap rises at the ecall's step[6], regs[3]=1, step=0 thereafter.
  - Stimulus: a second resetn pulse.
  - Response: trap=0, pc=0.
- x0 and illegal opcode:
  - Stimulus: addi x0,x0,7.
  - Response: regs[0] stays 0.
  - Stimulus: word 32'h0000007F.
  - Response: trap=1, no register written.
